// File: rtl/outport_uart_if.sv
// outport_uart_if -- bundles the datapath word input and the UART status/line
// outputs of outport_uart. The master side drives the word; the slave (the
// UART itself) drives the serial line and the FIFO status.
interface outport_uart_if #(
   parameter int DATAWIDTH_BUS = 32,
   parameter int FIFO_DEPTH    = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [DATAWIDTH_BUS-1:0] OUTPORT_UART_Data_InBus;
   logic                     OUTPORT_UART_TX_Out;
   logic                     OUTPORT_UART_Busy_Out;
   logic                     OUTPORT_UART_Full_Out;
   logic                     OUTPORT_UART_Overflow_Out;
   logic [CW-1:0]            OUTPORT_UART_Count_OutBus;

   modport master (
      output OUTPORT_UART_Data_InBus,
      input  OUTPORT_UART_TX_Out,
      input  OUTPORT_UART_Busy_Out,
      input  OUTPORT_UART_Full_Out,
      input  OUTPORT_UART_Overflow_Out,
      input  OUTPORT_UART_Count_OutBus
   );

   modport slave (
      input  OUTPORT_UART_Data_InBus,
      output OUTPORT_UART_TX_Out,
      output OUTPORT_UART_Busy_Out,
      output OUTPORT_UART_Full_Out,
      output OUTPORT_UART_Overflow_Out,
      output OUTPORT_UART_Count_OutBus
   );
endinterface

// File: rtl/outport_uart.sv
// outport_uart -- watches the datapath output register word; every change is
// queued in a small circular word FIFO and sent out on a UART line as four
// bytes, least significant byte first, 8 data bits LSB-first, one stop bit.
// Optional feature: define OUTPORT_UART_PARITY_EN to add one even-parity bit
// after the data bits of every byte.
module outport_uart #(
   parameter int DATAWIDTH_BUS = 32,
   parameter int CLKS_PER_BIT  = 434,
   parameter int FIFO_DEPTH    = 4
) (
   input logic           OUTPORT_UART_CLOCK_50,
   input logic           OUTPORT_UART_ResetInHigh_In,
   outport_uart_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   logic                     clk;
   logic                     rst;
   logic [DATAWIDTH_BUS-1:0] data_in;

   logic [DATAWIDTH_BUS-1:0] last;
   logic [DATAWIDTH_BUS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]            wr_ptr;
   logic [AW-1:0]            rd_ptr;
   logic [CW-1:0]            count;
   logic                     overflow;

   state_t                   state;
   logic [TW-1:0]            timer;
   logic [2:0]               bit_idx;
   logic [1:0]               byte_idx;
   logic [DATAWIDTH_BUS-1:0] shreg;
   logic                     tx;
`ifdef OUTPORT_UART_PARITY_EN
   logic                     par;
`endif

   logic change;
   logic pop;
   logic push;
   logic bit_end;

   assign clk     = OUTPORT_UART_CLOCK_50;
   assign rst     = OUTPORT_UART_ResetInHigh_In;
   assign data_in = bus.OUTPORT_UART_Data_InBus;

   assign change  = (data_in != last);
   assign pop     = (state == IDLE) && (count != '0);
   // A full FIFO still accepts a word when the transmitter frees a slot on the same edge.
   assign push    = change && ((count < DEPTH_C) || pop);
   assign bit_end = (timer == TIMER_MAX);

   // Word storage: written on every accepted push, no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Change detection, FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (change) begin
            last <= data_in;
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (change && !push) begin
            overflow <= 1'b1;
         end
      end
   end

   // Transmit FSM: pops a word, then sends four framed bytes with a registered line output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
`ifdef OUTPORT_UART_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               timer <= '0;
               tx    <= 1'b1;
               if (pop) begin
                  shreg    <= mem[rd_ptr];
                  byte_idx <= '0;
                  state    <= START;
                  tx       <= 1'b0;
               end
            end

            START: begin
               if (bit_end) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  tx      <= shreg[0];
`ifdef OUTPORT_UART_PARITY_EN
                  par     <= 1'b0;
`endif
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            // The shift register moves one bit per data bit, so after eight
            // shifts the next byte already sits in the low eight bits.
            DATA: begin
               if (bit_end) begin
                  timer <= '0;
                  shreg <= {1'b0, shreg[DATAWIDTH_BUS-1:1]};
`ifdef OUTPORT_UART_PARITY_EN
                  par   <= par ^ shreg[0];
`endif
                  if (bit_idx == 3'd7) begin
`ifdef OUTPORT_UART_PARITY_EN
                     state <= PARITY;
                     tx    <= par ^ shreg[0];
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[1];
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end

`ifdef OUTPORT_UART_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  timer <= '0;
                  state <= STOP;
                  tx    <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
`endif

            STOP: begin
               if (bit_end) begin
                  timer <= '0;
                  if (byte_idx != 2'd3) begin
                     byte_idx <= byte_idx + 2'd1;
                     state    <= START;
                     tx       <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            default: begin
               state <= IDLE;
               timer <= '0;
               tx    <= 1'b1;
            end
         endcase
      end
   end

   assign bus.OUTPORT_UART_TX_Out       = tx;
   assign bus.OUTPORT_UART_Busy_Out     = (state != IDLE);
   assign bus.OUTPORT_UART_Full_Out     = (count == DEPTH_C);
   assign bus.OUTPORT_UART_Overflow_Out = overflow;
   assign bus.OUTPORT_UART_Count_OutBus = count;
endmodule

// File: doc/outport_uart.md
OUTPORT_UART -- requirements
Module: outport_uart

Interface
REQ-001 SHALL provide parameter DATAWIDTH_BUS, default 32: width of the captured output word, fixed at 32 (4 bytes).
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 434: clock cycles per UART bit (115200 baud at 50 MHz); legal range is 2 or more.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4: word FIFO depth; must be a power of 2, at least 2.
REQ-004 SHALL provide port OUTPORT_UART_CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL provide port OUTPORT_UART_ResetInHigh_In  in  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port OUTPORT_UART_Data_InBus  in  32  output-register word from the system datapath (Rout).
REQ-007 SHALL provide port OUTPORT_UART_TX_Out  out  1  UART serial line; idle high.
REQ-008 SHALL provide port OUTPORT_UART_Busy_Out  out  1  high while the FSM is outside IDLE.
REQ-009 SHALL provide port OUTPORT_UART_Full_Out  out  1  high when the FIFO holds FIFO_DEPTH words.
REQ-010 SHALL provide port OUTPORT_UART_Overflow_Out  out  1  sticky flag: a changed word was dropped.
REQ-011 SHALL provide port OUTPORT_UART_Count_OutBus  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 SHALL hold register LAST (32 bits); a change is present in any cycle where Data_InBus != LAST.
REQ-013 SHALL, on a clock edge with a change present, load LAST with Data_InBus and push Data_InBus into the FIFO if a slot is available.
REQ-014 SHALL treat a slot as available when Count < FIFO_DEPTH, or when Count == FIFO_DEPTH and a pop occurs on the same edge; in the latter case Count is unchanged.
REQ-015 SHALL, on a change with no slot available, drop the word, still update LAST, and set Overflow_Out to 1 on that edge; Overflow_Out remains 1 until reset.
REQ-016 SHALL, on a simultaneous push and pop with Count < FIFO_DEPTH, leave Count unchanged; a pop with Count == 0 shall never occur.
REQ-017 SHALL implement the FIFO as a circular buffer whose read and write pointers wrap modulo FIFO_DEPTH.
REQ-018 SHALL implement the transmit FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL, in IDLE with Count > 0, pop the head word into a 32-bit shift register on one edge, clear the byte index to 0, and enter START.
REQ-020 SHALL drive TX_Out low in START, the current byte's bits LSB-first in DATA, and high in STOP; each bit lasts exactly CLKS_PER_BIT cycles, timed by a bit-timer that wraps at CLKS_PER_BIT-1.
REQ-021 SHALL transmit bytes in the order byte0 = [7:0], byte1 = [15:8], byte2 = [23:16], byte3 = [31:24].
REQ-022 SHALL, at the end of STOP, enter START for the next byte if the byte index < 3, otherwise return to IDLE.
REQ-023 SHALL make a word occupy 40*CLKS_PER_BIT cycles of line time (44*CLKS_PER_BIT with parity), plus 1 IDLE cycle before the next pop.
REQ-024 SHALL allow a push on the same edge the FSM pops.
REQ-025 SHALL make Busy_Out, Full_Out and Count_OutBus registered-state decodes, valid in the cycle after the edge that changes them.

Reset
REQ-026 SHALL, while reset is asserted, hold: FSM = IDLE, TX_Out = 1, Busy_Out = 0, Full_Out = 0, Count = 0, Overflow_Out = 0, LAST = 0, pointers = 0, bit-timer = 0, byte index = 0.
REQ-027 SHALL, on reset mid-frame, abort the frame immediately, return TX_Out high, and discard all FIFO contents.
REQ-028 SHALL, when reset is released with Data_InBus != 0, detect a change on the first edge and enqueue that word.

Configuration
REQ-029 SHALL, with OUTPORT_UART_PARITY_EN defined, pass through PARITY after DATA and send one even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-030 SHALL, without OUTPORT_UART_PARITY_EN, skip PARITY entirely and go DATA -> STOP; PARITY logic shall not be synthesised.

Verification (CLKS_PER_BIT = 4, FIFO_DEPTH = 4)
REQ-031 SHALL cover: after reset, Data_InBus 0 -> 0x000000A5 -> line carries bytes A5,00,00,00, each as start 0, data LSB-first, stop 1, 40*4 = 160 cycles total; Busy_Out falls after the last stop bit.
REQ-032 SHALL cover: Data_InBus held constant at 0x12345678 for 500 cycles -> exactly one word sent (78,56,34,12).
REQ-033 SHALL cover: 6 distinct values on consecutive cycles while the first word transmits -> first popped, next 4 queued, Full_Out = 1, 6th dropped, Overflow_Out = 1 and sticky.
REQ-034 SHALL cover: change with Count = 4 on the edge the FSM pops -> word accepted, Count stays 4, Overflow_Out stays 0.
REQ-035 SHALL cover: reset asserted during byte1 of a frame -> TX_Out = 1 asynchronously, Count = 0, no further bits sent.
REQ-036 SHALL cover: with OUTPORT_UART_PARITY_EN, byte 0x07 -> parity bit 1, word time 176 cycles.
